systolic_array_controller: RTL

//  OBI slave that sequences the HEEPstor systolic array datapath. Host writes weight rows and input

---
 rtl/heepstor_pkg.sv | 42 ++++
 rtl/systolic_array_controller_if.sv | 17 +
 rtl/systolic_array_ctrl_regif.sv | 80 ++++++++
 rtl/systolic_array_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/heepstor_pkg.sv
// +----------------------------------------------------------------------------+
// | heepstor_pkg : shared types and register map for the systolic array ctrl   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package heepstor_pkg;

    localparam int DEFAULT_SA_SIZE = 4;
    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_ACC_W   = 32;

    localparam logic [19:0] REG_STATUS = 20'h00000;
    localparam logic [19:0] REG_CTRL   = 20'h00004;
    localparam logic [19:0] REG_WEIGHT = 20'h00010;
    localparam logic [19:0] REG_INPUT  = 20'h00014;
    localparam logic [19:0] REG_RESULT = 20'h00040;

    typedef enum logic [2:0] {
        SA_IDLE    = 3'd0,
        SA_LOAD_W  = 3'd1,
        SA_FEED    = 3'd2,
        SA_WAIT    = 3'd3,
        SA_CAPTURE = 3'd4
    } sa_ctrl_state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

`default_nettype wire

// File: rtl/systolic_array_controller_if.sv
// +----------------------------------------------------------------------------+
// | systolic_array_controller_if : OBI request/response bundle                 |
// | Revision                     : 1.0                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface systolic_array_controller_if;
    import heepstor_pkg::*;

    obi_req_t  obi_req;
    obi_resp_t obi_resp;

    modport master (output obi_req, input  obi_resp);
    modport slave  (input  obi_req, output obi_resp);
endinterface

`default_nettype wire

// File: rtl/systolic_array_ctrl_regif.sv
// +----------------------------------------------------------------------------+
// | systolic_array_ctrl_regif : OBI address decode, grant and read-data stage  |
// | Revision                  : 1.0                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module systolic_array_ctrl_regif
    import heepstor_pkg::*;
#(
    parameter int SA_SIZE = DEFAULT_SA_SIZE,
    parameter int ACC_W   = DEFAULT_ACC_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    systolic_array_controller_if.slave obi_bus,
    input  logic                     busy_i,
    input  logic [31:0]              status_i,
    input  logic [SA_SIZE*ACC_W-1:0] result_i,
    output logic                     weight_wr_o,
    output logic                     input_wr_o,
    output logic                     ctrl_wr_o,
    output logic [31:0]              wdata_o
);

    logic [19:0] addr;
    logic        req;
    logic        we;
    logic        gnt;
    logic        is_array_wr;
    logic [31:0] rd_val;
    logic        rvalid_d, rvalid_q;
    logic [31:0] rdata_d, rdata_q;
    logic        unused_addr_hi;

    assign addr           = obi_bus.obi_req.addr[19:0];
    assign req            = obi_bus.obi_req.req;
    assign we             = obi_bus.obi_req.we;
    assign unused_addr_hi = ^obi_bus.obi_req.addr[31:20];

    // Only array-touching writes stall; everything else completes immediately.
    assign is_array_wr = we && ((addr == REG_WEIGHT) || (addr == REG_INPUT));
    assign gnt         = rst_n && req && !(busy_i && is_array_wr);

    assign weight_wr_o = gnt && we && (addr == REG_WEIGHT);
    assign input_wr_o  = gnt && we && (addr == REG_INPUT);
    assign ctrl_wr_o   = gnt && we && (addr == REG_CTRL);
    assign wdata_o     = obi_bus.obi_req.wdata;

    always_comb begin
        rd_val = 32'd0;
        if (addr == REG_STATUS) begin
            rd_val = status_i;
        end
        for (int i = 0; i < SA_SIZE; i++) begin
            if (addr == REG_RESULT + 20'(4 * i)) begin
                rd_val = result_i[i*ACC_W +: ACC_W];
            end
        end
    end

    always_comb begin
        rvalid_d = gnt;
        rdata_d  = (gnt && !we) ? rd_val : 32'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign obi_bus.obi_resp = {gnt, rvalid_q, rdata_q};

endmodule

`default_nettype wire

// File: rtl/systolic_array_controller.sv
// +----------------------------------------------------------------------------+
// | systolic_array_controller : OBI slave sequencing weight load, feed, capture|
// | Revision                  : 1.0                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module systolic_array_controller
    import heepstor_pkg::*;
#(
    parameter int SA_SIZE    = DEFAULT_SA_SIZE,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ACC_W      = DEFAULT_ACC_W,
    parameter int SA_LATENCY = 2 * SA_SIZE - 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    systolic_array_controller_if.slave  obi_bus,
    output logic                        sa_weight_we_o,
    output logic [$clog2(SA_SIZE)-1:0]  sa_weight_row_o,
    output logic [SA_SIZE*DATA_W-1:0]   sa_weight_data_o,
    output logic                        sa_in_valid_o,
    output logic [SA_SIZE*DATA_W-1:0]   sa_in_data_o,
    output logic                        sa_clear_o,
    input  logic [SA_SIZE*ACC_W-1:0]    sa_out_data_i
);

    localparam int ROW_W     = $clog2(SA_SIZE);
    localparam int ROW_W_STS = 8;
    localparam int WAIT_LAST = (SA_LATENCY >= 2) ? SA_LATENCY - 2 : 0;

    sa_ctrl_state_e              state_d, state_q;
    logic [ROW_W-1:0]            row_ptr_d, row_ptr_q;
    logic [7:0]                  wait_cnt_d, wait_cnt_q;
    logic                        result_valid_d, result_valid_q;
    logic [SA_SIZE*ACC_W-1:0]    results_d, results_q;
    logic                        weight_we_d, weight_we_q;
    logic [ROW_W-1:0]            weight_row_d, weight_row_q;
    logic [SA_SIZE*DATA_W-1:0]   weight_data_d, weight_data_q;
    logic                        in_valid_d, in_valid_q;
    logic [SA_SIZE*DATA_W-1:0]   in_data_d, in_data_q;
    logic                        clear_d, clear_q;

    logic        busy;
    logic [31:0] status;
    logic        weight_wr, input_wr, ctrl_wr;
    logic [31:0] wdata;
    logic        soft_rst, clr_rv;

    assign busy   = (state_q != SA_IDLE);
    assign status = {16'd0, ROW_W_STS'(row_ptr_q), 6'd0, result_valid_q, busy};

    systolic_array_ctrl_regif #(
        .SA_SIZE (SA_SIZE),
        .ACC_W   (ACC_W)
    ) u_regif (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .obi_bus     (obi_bus),
        .busy_i      (busy),
        .status_i    (status),
        .result_i    (results_q),
        .weight_wr_o (weight_wr),
        .input_wr_o  (input_wr),
        .ctrl_wr_o   (ctrl_wr),
        .wdata_o     (wdata)
    );

    assign soft_rst = ctrl_wr && wdata[0];
    assign clr_rv   = ctrl_wr && wdata[1];

    always_comb begin
        state_d        = state_q;
        row_ptr_d      = row_ptr_q;
        wait_cnt_d     = wait_cnt_q;
        result_valid_d = result_valid_q;
        results_d      = results_q;
        weight_we_d    = 1'b0;
        weight_row_d   = weight_row_q;
        weight_data_d  = weight_data_q;
        in_valid_d     = 1'b0;
        in_data_d      = in_data_q;
        clear_d        = 1'b0;

        unique case (state_q)
            SA_IDLE: begin
                if (weight_wr) begin
                    state_d       = SA_LOAD_W;
                    weight_we_d   = 1'b1;
                    weight_row_d  = row_ptr_q;
                    weight_data_d = wdata;
                    row_ptr_d     = (row_ptr_q == ROW_W'(SA_SIZE - 1)) ? '0
                                                                       : row_ptr_q + ROW_W'(1);
                end else if (input_wr) begin
                    state_d        = SA_FEED;
                    in_valid_d     = 1'b1;
                    in_data_d      = wdata;
                    result_valid_d = 1'b0;
                end
            end
            SA_LOAD_W: state_d = SA_IDLE;
            SA_FEED: begin
                wait_cnt_d = 8'd0;
                state_d    = (SA_LATENCY == 1) ? SA_CAPTURE : SA_WAIT;
            end
            SA_WAIT: begin
                // FEED + (SA_LATENCY-1) WAIT cycles puts CAPTURE on the result cycle.
                if (wait_cnt_q == 8'(WAIT_LAST)) begin
                    state_d    = SA_CAPTURE;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            SA_CAPTURE: begin
                results_d      = sa_out_data_i;
                result_valid_d = 1'b1;
                state_d        = SA_IDLE;
            end
            default: state_d = SA_IDLE;
        endcase

        if (clr_rv) begin
            result_valid_d = 1'b0;
        end

        // Soft reset overrides everything except the captured results.
        if (soft_rst) begin
            state_d        = SA_IDLE;
            row_ptr_d      = '0;
            wait_cnt_d     = 8'd0;
            result_valid_d = 1'b0;
            results_d      = results_q;
            weight_we_d    = 1'b0;
            in_valid_d     = 1'b0;
            clear_d        = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q        <= SA_IDLE;
            row_ptr_q      <= '0;
            wait_cnt_q     <= 8'd0;
            result_valid_q <= 1'b0;
            results_q      <= '0;
            weight_we_q    <= 1'b0;
            weight_row_q   <= '0;
            weight_data_q  <= '0;
            in_valid_q     <= 1'b0;
            in_data_q      <= '0;
            clear_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_ptr_q      <= row_ptr_d;
            wait_cnt_q     <= wait_cnt_d;
            result_valid_q <= result_valid_d;
            results_q      <= results_d;
            weight_we_q    <= weight_we_d;
            weight_row_q   <= weight_row_d;
            weight_data_q  <= weight_data_d;
            in_valid_q     <= in_valid_d;
            in_data_q      <= in_data_d;
            clear_q        <= clear_d;
        end
    end

    assign sa_weight_we_o   = weight_we_q;
    assign sa_weight_row_o  = weight_row_q;
    assign sa_weight_data_o = weight_data_q;
    assign sa_in_valid_o    = in_valid_q;
    assign sa_in_data_o     = in_data_q;
    assign sa_clear_o       = clear_q;

endmodule

`default_nettype wire
